// File: rtl/exc_sequencer.sv
// exc_sequencer: trap handoff FSM that saves EPC, fetches the handler vector byte and loads PC
module exc_sequencer #(
  parameter int N_CAUSE  = 3,
  parameter int CODE_W   = $clog2(N_CAUSE),
  parameter int ADDR_W   = 32,
  parameter int VEC_BASE = 253,
  parameter int MEM_LAT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_CAUSE-1:0] cause_req,
  output logic               busy,
  output logic [CODE_W-1:0]  cause_code,
  output logic               epc_we,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               pc_src_vec,
  output logic               pc_we,
  output logic               done,
  output logic               lost
);
  localparam logic [1:0] IDLE = 2'd0, SAVE = 2'd1, READ = 2'd2, LOAD = 2'd3;
  localparam int CNT_W = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  logic [1:0]        state, nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] win;
  logic              last, req;
  assign req  = |cause_req;
  assign last = cnt == CNT_W'(MEM_LAT - 1);
  // lowest set index wins, so scan downward and let later hits overwrite
  always_comb begin
    win = '0;
    for (int i = N_CAUSE - 1; i >= 0; i--) if (cause_req[i]) win = CODE_W'(i);
  end
  always_comb nxt = state == IDLE ? (req ? SAVE : IDLE) :
                    state == SAVE ? READ :
                    state == READ ? (last ? LOAD : READ) : IDLE;
  // outputs are decoded from the next state so they are registered yet aligned with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cause_code <= '0;
      lost       <= 1'b0;
      busy       <= 1'b0;
      epc_we     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      pc_src_vec <= 1'b0;
      pc_we      <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= nxt;
      cnt        <= (state == READ && !last) ? cnt + CNT_W'(1) : '0;
      cause_code <= (state == IDLE && req) ? win : cause_code;
      lost       <= lost | (state != IDLE && req);
      busy       <= nxt != IDLE;
      epc_we     <= nxt == SAVE;
      mem_rd     <= nxt == READ;
      mem_addr   <= nxt == READ ? ADDR_W'(VEC_BASE) + ADDR_W'(cause_code) : '0;
      pc_src_vec <= nxt == LOAD;
      pc_we      <= nxt == LOAD;
      done       <= nxt == LOAD;
    end
  end
endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: directed checks of the trap sequencer at default and long-latency settings
module tb_exc_sequencer;
  logic        clk = 1'b0, reset = 1'b1;
  logic [2:0]  cause_req = '0;
  logic        busy, epc_we, mem_rd, pc_src_vec, pc_we, done, lost;
  logic [1:0]  cause_code;
  logic [31:0] mem_addr;
  logic [3:0]  cause_req2 = '0;
  logic        busy2, epc_we2, mem_rd2, pc_src_vec2, pc_we2, done2, lost2;
  logic [1:0]  cause_code2;
  logic [31:0] mem_addr2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  exc_sequencer dut (
    .clk(clk), .reset(reset), .cause_req(cause_req), .busy(busy), .cause_code(cause_code),
    .epc_we(epc_we), .mem_rd(mem_rd), .mem_addr(mem_addr), .pc_src_vec(pc_src_vec),
    .pc_we(pc_we), .done(done), .lost(lost)
  );

  exc_sequencer #(.N_CAUSE(4), .VEC_BASE(100), .MEM_LAT(5)) dut2 (
    .clk(clk), .reset(reset), .cause_req(cause_req2), .busy(busy2), .cause_code(cause_code2),
    .epc_we(epc_we2), .mem_rd(mem_rd2), .mem_addr(mem_addr2), .pc_src_vec(pc_src_vec2),
    .pc_we(pc_we2), .done(done2), .lost(lost2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({busy, epc_we, mem_rd, pc_src_vec, pc_we, done, lost, cause_code, mem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b epc=%b rd=%b src=%b pcwe=%b done=%b lost=%b code=%0d addr=%0d, want all 0",
               busy, epc_we, mem_rd, pc_src_vec, pc_we, done, lost, cause_code, mem_addr);
    end
    checks++;
    if ({busy2, epc_we2, mem_rd2, pc_we2, lost2, mem_addr2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs2: got busy=%b epc=%b rd=%b pcwe=%b lost=%b addr=%0d, want all 0",
               busy2, epc_we2, mem_rd2, pc_we2, lost2, mem_addr2);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({busy, pc_we, epc_we} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got busy/pcwe/epc=%b, want 000", {busy, pc_we, epc_we});
    end
  endtask

  // one request cycle, then five cycles checking {busy,epc_we,mem_rd,pc_src_vec,pc_we,done} and mem_addr
  task automatic run_one(input logic [2:0] req, input logic [1:0] code, input logic [31:0] addr, input string name);
    logic [5:0] exp;
    cause_req = req;
    for (int c = 1; c <= 5; c++) begin
      step();
      cause_req = '0;
      exp = c == 1 ? 6'b110000 : (c <= 3 ? 6'b101000 : (c == 4 ? 6'b100111 : 6'b000000));
      checks++;
      if ({busy, epc_we, mem_rd, pc_src_vec, pc_we, done} !== exp) begin
        errors++;
        $display("FAIL %s_strobes c%0d: got %b, want %b", name, c, {busy, epc_we, mem_rd, pc_src_vec, pc_we, done}, exp);
      end
      checks++;
      if (mem_addr !== ((c == 2 || c == 3) ? addr : 32'd0)) begin
        errors++;
        $display("FAIL %s_addr c%0d: got %0d, want %0d", name, c, mem_addr, (c == 2 || c == 3) ? addr : 32'd0);
      end
    end
    checks++;
    if (cause_code !== code) begin
      errors++;
      $display("FAIL %s_code: got %0d, want %0d", name, cause_code, code);
    end
  endtask

  task automatic test_basic();
    run_one(3'b010, 2'd1, 32'd254, "basic");
    checks++;
    if (lost !== 1'b0) begin
      errors++;
      $display("FAIL basic_lost: got %b, want 0", lost);
    end
  endtask

  task automatic test_priority();
    run_one(3'b111, 2'd0, 32'd253, "priority");
    checks++;
    if (lost !== 1'b0) begin
      errors++;
      $display("FAIL priority_lost: got %b, want 0", lost);
    end
  endtask

  task automatic test_lost();
    cause_req = 3'b100;
    step();
    cause_req = '0;
    step();
    cause_req = 3'b001;
    step();
    cause_req = '0;
    checks++;
    if ({mem_rd, lost, cause_code, mem_addr} !== {1'b1, 1'b1, 2'd2, 32'd255}) begin
      errors++;
      $display("FAIL lost_read: got rd=%b lost=%b code=%0d addr=%0d, want 1 1 2 255", mem_rd, lost, cause_code, mem_addr);
    end
    step();
    checks++;
    if ({pc_we, done} !== 2'b11) begin
      errors++;
      $display("FAIL lost_load: got pcwe/done=%b, want 11", {pc_we, done});
    end
    for (int c = 0; c < 4; c++) step();
    checks++;
    if ({busy, lost, cause_code} !== {1'b0, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL lost_sticky: got busy=%b lost=%b code=%0d, want 0 1 2", busy, lost, cause_code);
    end
  endtask

  task automatic test_async_reset();
    cause_req = 3'b001;
    step();
    cause_req = '0;
    step();
    step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, epc_we, mem_rd, pc_src_vec, pc_we, done, lost, cause_code, mem_addr} !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b rd=%b pcwe=%b lost=%b addr=%0d, want all 0", busy, mem_rd, pc_we, lost, mem_addr);
    end
    step();
    checks++;
    if ({pc_we, done, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_no_pcwe: got pcwe/done/busy=%b, want 000", {pc_we, done, busy});
    end
    reset = 1'b0;
    step();
    run_one(3'b100, 2'd2, 32'd255, "after_reset");
    checks++;
    if (lost !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_lost: got %b, want 0", lost);
    end
  endtask

  task automatic test_mem_lat5();
    cause_req2 = 4'b1000;
    for (int c = 1; c <= 8; c++) begin
      step();
      cause_req2 = '0;
      checks++;
      if ({epc_we2, mem_rd2, pc_we2, busy2} !== {c == 1, c >= 2 && c <= 6, c == 7, c <= 7}) begin
        errors++;
        $display("FAIL lat5_strobes c%0d: got epc/rd/pcwe/busy=%b, want %b", c,
                 {epc_we2, mem_rd2, pc_we2, busy2}, {c == 1, c >= 2 && c <= 6, c == 7, c <= 7});
      end
      checks++;
      if (mem_addr2 !== ((c >= 2 && c <= 6) ? 32'd103 : 32'd0)) begin
        errors++;
        $display("FAIL lat5_addr c%0d: got %0d, want %0d", c, mem_addr2, (c >= 2 && c <= 6) ? 32'd103 : 32'd0);
      end
    end
    checks++;
    if (cause_code2 !== 2'd3) begin
      errors++;
      $display("FAIL lat5_code: got %0d, want 3", cause_code2);
    end
  endtask

  task automatic test_back_to_back();
    cause_req = 3'b010;
    for (int c = 1; c <= 15; c++) begin
      step();
      checks++;
      if ({epc_we, pc_we} !== {c % 5 == 1, c % 5 == 4}) begin
        errors++;
        $display("FAIL b2b c%0d: got epc/pcwe=%b, want %b", c, {epc_we, pc_we}, {c % 5 == 1, c % 5 == 4});
      end
    end
    cause_req = '0;
    for (int c = 0; c < 6; c++) step();
    checks++;
    if ({busy, cause_code} !== {1'b0, 2'd1}) begin
      errors++;
      $display("FAIL b2b_end: got busy=%b code=%0d, want 0 1", busy, cause_code);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_lost();
    test_async_reset();
    test_mem_lat5();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
